mic_sequencer: RTL
==================

# mic_sequencer

Microprogram sequencer for the microcoded datapath: it holds the control store, fetches one 36-bit microinstruction per cycle and drives the datapath control fields. It produces the 8-bit ALU control word, the C-bus write enables, the memory command and the B-bus select. It consumes the ALU N/Z flags and the MBR to compute the next microaddress (JAMN/JAMZ/JMPC). It is the producer end of the ALU control/flag interface.

## Interface
Parameters:
- ADDR_W, 9, microaddress width; store depth 2^ADDR_W.
- RESET_VEC, 9'h000, first microaddress fetched on start.
- HALT_ADDR, 9'h1FF, reserved address; branching to it halts.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  level; begin execution from IDLE or HALTED.
- stall  in  1  memory wait; freezes sequencing in RUN.
- ld_en  in  1  control-store write strobe.
- ld_addr  in  9  write address.
- ld_data  in  36  write data.
- alu_n  in  1  ALU N flag (combinational from the current cycle).
- alu_z  in  1  ALU Z flag.
- mbr  in  8  MBR byte for JMPC dispatch.
- alu_control  out  8  {SLL8,SRA1,F0,F1,ENA,ENB,INVA,INC}.
- c_sel  out  9  C-bus register write enables.
- mem_ctl  out  3  {WRITE,READ,FETCH}.
- b_sel  out  4  B-bus source select.
- mpc  out  9  address of the microinstruction currently in MIR.
- running  out  1  high in RUN.
- halted  out  1  high in HALTED.

## Operation
- Microinstruction layout: [35:27] NEXT_ADDR, [26] JMPC, [25] JAMN, [24] JAMZ, [23:16] ALU control, [15:7] C, [6:4] MEM, [3:0] B.
- Next address:
  - next_mpc[8] = NEXT_ADDR[8] | (JAMN & alu_n) | (JAMZ & alu_z).
  - next_mpc[7:0] = NEXT_ADDR[7:0] | (JMPC ? mbr : 8'h00).
  - Bitwise OR only; no carry.
- States:
  - IDLE: after reset.
    - Control outputs are 0.
    - ld_en writes the store.
    - start with ld_en low → PRIME. start with ld_en high is ignored that cycle.
  - PRIME: store read at RESET_VEC. Next edge: MIR loaded, mpc=RESET_VEC → RUN. stall is ignored in PRIME.
  - RUN: outputs are driven from MIR.
    - stall=0 edge: MIR ← store[next_mpc], mpc ← next_mpc.
    - If next_mpc == HALT_ADDR: → HALTED, MIR cleared, mpc=HALT_ADDR.
    - stall=1 edge: MIR and mpc hold; outputs hold.
  - HALTED: outputs are 0 and the store is writable. start (with ld_en low) → PRIME.
- ld_en is ignored in PRIME and RUN.
- Outputs outside RUN are forced to 0. c_sel=0 and mem_ctl=0 guarantee no side effects.
- An all-zero alu_control does not decode in the ALU; this is harmless.

## Timing
- One microinstruction per unstalled cycle.
- alu_n/alu_z are sampled at the same edge that ends the microinstruction producing them.
- Store read is synchronous, 1 cycle. The read address is next_mpc, so MIR and mpc update together.
- Start latency: start sampled at edge k → PRIME during cycle k+1 → first MIR valid, running=1 after edge k+2.
- Reset values: state IDLE, mpc=0, MIR=0; all outputs 0, running=0, halted=0. Store contents are not reset.
- Reset mid-RUN: IDLE on the next edge, store retained, no further outputs.
- Write collision: a write in IDLE/HALTED never coincides with a read (reads occur only in PRIME/RUN).

## Structure
- Package mic_pkg:
  - mic_word_t packed struct for the field layout.
  - state enum {IDLE, PRIME, RUN, HALTED}.
  - Field-width constants.
  - ALU control constants (e.g. ALU_A=8'h18, ALU_ADD=8'h3C, ALU_B_MINUS_A=8'h3F).
- Sub-module control_store: 512×36 single-port synchronous RAM.
  - Write port from ld_*; read port addressed by next_mpc (PRIME: RESET_VEC).

## Test plan
- Reset: assert reset 2 cycles → mpc=0, alu_control=0, c_sel=0, mem_ctl=0, running=0, halted=0.
- Straight line: load [0]={NEXT=1, ALU=8'h3C, C=9'h001}, [1]={NEXT=9'h1FF, ALU=8'h18}; start → cycle k+2 mpc=0, alu_control=8'h3C, c_sel=1; k+3 mpc=1, alu_control=8'h18; k+4 halted=1, outputs 0.
- JAMZ: [0]={NEXT=9'h005, JAMZ=1}; alu_z=1 → mpc=9'h105; rerun with alu_z=0 → mpc=9'h005. Repeat with JAMN/alu_n for 9'h105.
- JMPC: [0]={NEXT=9'h100, JMPC=1}, mbr=8'h2A → mpc=9'h12A.
- Stall: hold stall=1 for 3 cycles in RUN → mpc and all outputs constant; release → advances exactly one step per cycle.
- Reset at 2nd RUN cycle → IDLE, outputs 0; start again → re-executes from RESET_VEC with the same store contents. ld_en pulsed during RUN leaves the store unchanged.

Source files
------------

// File: rtl/mic_pkg.sv
// Shared types and constants for the microprogram sequencer: microword layout,
// sequencer states, ALU control encodings and the next-address function.
package mic_pkg;

  localparam int unsigned ADDR_BITS = 9;
  localparam int unsigned ALU_BITS  = 8;
  localparam int unsigned C_BITS    = 9;
  localparam int unsigned MEM_BITS  = 3;
  localparam int unsigned B_BITS    = 4;
  localparam int unsigned WORD_BITS = 36;

  typedef struct packed {
    logic [ADDR_BITS-1:0] next_addr;
    logic                 jmpc;
    logic                 jamn;
    logic                 jamz;
    logic [ALU_BITS-1:0]  alu;
    logic [C_BITS-1:0]    c;
    logic [MEM_BITS-1:0]  mem;
    logic [B_BITS-1:0]    b;
  } mic_word_t;

  typedef logic [1:0] state_t;
  localparam state_t IDLE   = 2'd0;
  localparam state_t PRIME  = 2'd1;
  localparam state_t RUN    = 2'd2;
  localparam state_t HALTED = 2'd3;

  // {SLL8,SRA1,F0,F1,ENA,ENB,INVA,INC}
  localparam logic [ALU_BITS-1:0] ALU_A         = 8'h18;
  localparam logic [ALU_BITS-1:0] ALU_ADD       = 8'h3C;
  localparam logic [ALU_BITS-1:0] ALU_B_MINUS_A = 8'h3F;

  // Branch bits are OR-ed in, never added: no carry between fields.
  function automatic logic [ADDR_BITS-1:0] calc_next(input mic_word_t w,
                                                     input logic n,
                                                     input logic z,
                                                     input logic [7:0] mbr);
    logic [ADDR_BITS-1:0] a;
    a[8]   = w.next_addr[8] | (w.jamn & n) | (w.jamz & z);
    a[7:0] = w.next_addr[7:0] | (w.jmpc ? mbr : 8'h00);
    return a;
  endfunction

endpackage

// File: rtl/mic_sequencer_control_store.sv
// Single-port synchronous control store; the registered read data is the MIR.
module control_store #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 36
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic              clr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (clr)     rdata <= '0;
    else if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/mic_sequencer.sv
// Microprogram sequencer: fetches one microword per unstalled cycle and drives
// the datapath control fields, branching on ALU flags and the MBR byte.
module mic_sequencer
  import mic_pkg::*;
#(
  parameter int unsigned          ADDR_W    = 9,
  parameter logic [ADDR_W-1:0]    RESET_VEC = 9'h000,
  parameter logic [ADDR_W-1:0]    HALT_ADDR = 9'h1FF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stall,
  input  logic        ld_en,
  input  logic [8:0]  ld_addr,
  input  logic [35:0] ld_data,
  input  logic        alu_n,
  input  logic        alu_z,
  input  logic [7:0]  mbr,
  output logic [7:0]  alu_control,
  output logic [8:0]  c_sel,
  output logic [2:0]  mem_ctl,
  output logic [3:0]  b_sel,
  output logic [8:0]  mpc,
  output logic        running,
  output logic        halted
);

  state_t            state;
  logic [WORD_BITS-1:0] mir_bits;
  mic_word_t         mir;
  logic [ADDR_W-1:0] next_mpc;
  logic              idle_like, go, advance, to_halt;
  logic              we, re, clr;
  logic [ADDR_W-1:0] store_addr;

  assign mir      = mic_word_t'(mir_bits);
  assign next_mpc = calc_next(mir, alu_n, alu_z, mbr);

  assign idle_like = (state == IDLE) || (state == HALTED);
  assign go        = idle_like && start && !ld_en;
  assign advance   = (state == RUN) && !stall;
  assign to_halt   = advance && (next_mpc == HALT_ADDR);

  // Writes happen only in IDLE/HALTED and reads only in PRIME/RUN, so one port suffices.
  assign we         = idle_like && ld_en;
  assign re         = (state == PRIME) || advance;
  assign clr        = reset || to_halt;
  assign store_addr = we ? ld_addr : ((state == PRIME) ? RESET_VEC : next_mpc);

  control_store #(
    .ADDR_W (ADDR_W),
    .DATA_W (WORD_BITS)
  ) u_store (
    .clk   (clk),
    .we    (we && !reset),
    .re    (re),
    .clr   (clr),
    .addr  (store_addr),
    .wdata (ld_data),
    .rdata (mir_bits)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      mpc   <= '0;
    end else begin
      case (state)
        IDLE, HALTED: if (go) state <= PRIME;
        PRIME: begin
          state <= RUN;
          mpc   <= RESET_VEC;
        end
        RUN: if (advance) begin
          mpc <= next_mpc;
          if (to_halt) state <= HALTED;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign running     = (state == RUN);
  assign halted      = (state == HALTED);
  assign alu_control = running ? mir.alu : '0;
  assign c_sel       = running ? mir.c   : '0;
  assign mem_ctl     = running ? mir.mem : '0;
  assign b_sel       = running ? mir.b   : '0;

endmodule
